neuron_mac: RTL and testbench
=============================

# neuron_mac

Sequential dot-product engine that computes one neuron's pre-activation, y = Σ x[i]·w[i] + bias, in signed Q8.24, with a full-precision accumulator. It sits directly upstream of the combinational `tanh` activation stage. Its registered `y` output feeds `tanh`'s `a` input, and `out_valid`/`out_ready` qualify that result for the consumer. Operands stream in one (x, w) pair per accepted beat under a valid/ready handshake.

## Interface
- `WIDTH`, 32, data width of x, w, bias and y (signed fixed point).
- `FL`, 24, fractional bits (Q8.24 at defaults).
- `N_IN`, 4, number of (x, w) pairs per dot product; ≥1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a new dot product; honoured only in IDLE.
- `bias` input WIDTH: signed bias, latched on accepted `start`.
- `in_valid` input 1: x/w beat valid.
- `in_ready` output 1: block accepts a beat.
- `x` input WIDTH: signed input activation.
- `w` input WIDTH: signed weight.
- `out_valid` output 1: `y` holds a finished result.
- `out_ready` input 1: consumer accepts `y`.
- `y` output WIDTH: signed pre-activation result, registered.
- `busy` output 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACC, FIN, OUT.
- IDLE: `in_ready`=0. When `start`=1, latch `bias`, clear the accumulator and beat counter, and go to ACC.
- ACC: `in_ready`=1. Each cycle with `in_valid`&&`in_ready`:
  - acc += x·w, using a full 2·WIDTH signed product.
  - counter++.
  - On the N_IN-th beat, go to FIN.
  - Cycles without `in_valid` hold all state.
- FIN (exactly 1 cycle): y_reg ← fmt((acc >>> FL) + sign_ext(bias)). Go to OUT.
- OUT: `out_valid`=1 and `y` is held stable. When `out_ready`=1, go to IDLE.
- Accumulator width is 2·WIDTH + ceil(log2(N_IN)) + 1, so the accumulator never overflows.
- `>>>` is an arithmetic shift. Truncation rounds toward −∞.
- fmt() saturates or truncates, per the Configuration section.
- `start` outside IDLE is ignored. `in_valid` outside ACC is ignored and `in_ready` is 0 there.
- `y` keeps its last value after the OUT handshake until the next FIN.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `busy`=0, `y`=0, accumulator=0, counter=0, state=IDLE.
- `rst` asserted in any state, including mid-ACC or mid-OUT, aborts the operation. Next cycle all reset values apply and partial sums are discarded.
- Cycle 0 = `start` sampled in IDLE. `in_ready` rises in cycle 1.
- Best case, with `in_valid` always high: beats are accepted in cycles 1..N_IN, FIN is cycle N_IN+1, and `out_valid` rises in cycle N_IN+2.
- Latency from the last accepted beat to `out_valid` is 2 cycles.
- The OUT→IDLE handshake completes in the cycle where `out_valid`&&`out_ready`.
- A new `start` is accepted no earlier than the following cycle, in IDLE, giving a minimum issue interval of N_IN+3 cycles.
- `start` and `rst` asserted together: `rst` wins.

## Configuration
- `NEURON_MAC_SAT_EN` defined: fmt() clamps the wide sum to [−2^(WIDTH−1), 2^(WIDTH−1)−1], i.e. 0x80000000..0x7FFFFFFF at defaults.
- `NEURON_MAC_SAT_EN` undefined: fmt() keeps the low WIDTH bits (two's-complement wrap). No saturation logic is generated.

## Test plan
All scenarios use the defaults (WIDTH=32, FL=24, N_IN=4).
- Basic: x=0x01000000 (1.0) and w=0x00800000 (0.5) on all 4 beats, bias=0 → `y`=0x02000000, `out_valid` 2 cycles after beat 4.
- Negative plus bias: x=0xFF000000 (−1.0), w=0x00400000 (0.25) ×4, bias=0x00400000 → `y`=0xFF400000 (−0.75).
- Overflow: x=w=0x7F000000 (127.0) ×4, bias=0.
  - With `NEURON_MAC_SAT_EN`: `y`=0x7FFFFFFF.
  - Without it: `y`=0x04000000.
- Stalls and backpressure:
  - Basic vectors with `in_valid` low for 3 cycles between beats 2 and 3 → `y`=0x02000000, counter not advanced during the gap.
  - `out_ready` held low 5 cycles in OUT → `out_valid`=1 and `y` unchanged throughout; IDLE follows the handshake.
- Reset mid-op: `rst`=1 after beat 2 → next cycle `busy`=0, `in_ready`=0, `y`=0. A fresh Basic run then yields 0x02000000 with no residue.
- Ignored inputs: pulse `start` during ACC and OUT with a different bias → no effect on the result. `in_valid` in IDLE → no accumulation.

Source files
------------

// File: rtl/neuron_mac.sv
// Sequential dot-product neuron pre-activation y = sum(x*w) + bias in signed fixed point.
// Optional output saturation is enabled by defining NEURON_MAC_SAT_EN; default build wraps.
module neuron_mac #(
  parameter int WIDTH = 32,
  parameter int FL    = 24,
  parameter int N_IN  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] w,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             busy
);

  localparam int ACC_W = 2*WIDTH + $clog2(N_IN) + 1;
  localparam int CNT_W = $clog2(N_IN + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, FIN = 2'd2, OUT = 2'd3} state_t;

  state_t                    state_r;
  state_t                    state_next_s;
  logic signed [ACC_W-1:0]   acc_r;
  logic        [CNT_W-1:0]   cnt_r;
  logic signed [WIDTH-1:0]   bias_r;
  logic        [WIDTH-1:0]   y_r;
  logic                      in_ready_r;
  logic                      out_valid_r;
  logic                      busy_r;
  logic signed [2*WIDTH-1:0] prod_s;
  logic signed [ACC_W-1:0]   sum_s;
  logic                      last_beat_s;

  // Narrow the wide sum to the output width (clamp or two's-complement wrap).
  function automatic logic [WIDTH-1:0] fmt(input logic signed [ACC_W-1:0] v);
`ifdef NEURON_MAC_SAT_EN
    logic signed [ACC_W-1:0] max_v;
    logic signed [ACC_W-1:0] min_v;
    max_v = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    min_v = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    if (v > max_v) begin
      fmt = WIDTH'(max_v);
    end else if (v < min_v) begin
      fmt = WIDTH'(min_v);
    end else begin
      fmt = WIDTH'(v);
    end
`else
    fmt = WIDTH'(v);
`endif
  endfunction

  assign prod_s      = $signed(x) * $signed(w);
  assign sum_s       = (acc_r >>> FL) + ACC_W'(bias_r);
  assign last_beat_s = (cnt_r == CNT_W'(N_IN - 1));

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = ACC;
        else       state_next_s = IDLE;
      end
      ACC: begin
        if (in_valid && last_beat_s) state_next_s = FIN;
        else                         state_next_s = ACC;
      end
      FIN: state_next_s = OUT;
      OUT: begin
        if (out_ready) state_next_s = IDLE;
        else           state_next_s = OUT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State register and registered handshake/status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      in_ready_r  <= (state_next_s == ACC);
      out_valid_r <= (state_next_s == OUT);
      busy_r      <= (state_next_s != IDLE);
    end
  end

  // Datapath: bias latch, accumulation, and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r  <= {ACC_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      bias_r <= {WIDTH{1'b0}};
      y_r    <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            bias_r <= bias;
            acc_r  <= {ACC_W{1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
          end
        end
        ACC: begin
          if (in_valid) begin
            acc_r <= acc_r + ACC_W'(prod_s);
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        FIN:     y_r <= fmt(sum_s);
        default: y_r <= y_r;
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign y         = y_r;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed self-checking bench for neuron_mac at default parameters.
module tb_neuron_mac;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x;
  logic [31:0] w;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef NEURON_MAC_SAT_EN
  localparam logic [31:0] EXP_OVF = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] EXP_OVF = 32'h0400_0000;
`endif

  neuron_mac dut (
    .clk(clk), .rst(rst), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .w(w),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bounded wait for out_valid; returns cycles waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", {31'b0, out_valid}, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] b, input logic [31:0] xv, input logic [31:0] wv, input int gap);
    int n;
    start = 1'b1; bias = b;
    @(negedge clk);
    start = 1'b0; bias = 32'h5A5A_5A5A;
    check("in_ready_acc", {31'b0, in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          @(negedge clk);
          check("stall_hold", {30'b0, in_ready, out_valid}, 32'd2);
        end
      end
      in_valid = 1'b1; x = xv; w = wv;
      @(negedge clk);
    end
    in_valid = 1'b0; x = 32'h0; w = 32'h0;
    check("fin_no_valid", {31'b0, out_valid}, 32'd0);
    wait_out(n);
    check("latency", n, 32'd1);
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_out_valid", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b1; bias = 32'h1234_5678;
    in_valid = 1'b0; out_ready = 1'b0; x = 32'h0; w = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_y", y, 32'h0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    // Basic
    run_op(32'h0, 32'h0100_0000, 32'h0080_0000, 0);
    check("basic_y", y, 32'h0200_0000);
    handshake();
    check("y_held_idle", y, 32'h0200_0000);

    // Negative plus bias
    run_op(32'h0040_0000, 32'hFF00_0000, 32'h0040_0000, 0);
    check("neg_y", y, 32'hFF40_0000);
    handshake();

    // Overflow
    run_op(32'h0, 32'h7F00_0000, 32'h7F00_0000, 0);
    check("ovf_y", y, EXP_OVF);
    handshake();

    // Stall between beats 2 and 3, then backpressure in OUT
    run_op(32'h0, 32'h0100_0000, 32'h0080_0000, 3);
    check("stall_y", y, 32'h0200_0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", {31'b0, out_valid}, 32'd1);
      check("bp_y", y, 32'h0200_0000);
    end
    handshake();

    // Reset mid-operation after two beats
    start = 1'b1; bias = 32'h0100_0000;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; x = 32'h0100_0000; w = 32'h0080_0000;
    repeat (2) @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_in_ready", {31'b0, in_ready}, 32'd0);
    check("abort_y", y, 32'h0);
    run_op(32'h0, 32'h0100_0000, 32'h0080_0000, 0);
    check("post_rst_y", y, 32'h0200_0000);
    handshake();

    // start during ACC and OUT is ignored
    start = 1'b1; bias = 32'h0;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1; x = 32'h0100_0000; w = 32'h0080_0000;
    @(negedge clk);
    start = 1'b1; bias = 32'h1000_0000;
    @(negedge clk);
    start = 1'b0; bias = 32'h0;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    wait_out(n);
    check("ign_acc_y", y, 32'h0200_0000);
    start = 1'b1; bias = 32'h2000_0000;
    @(negedge clk);
    start = 1'b0;
    check("ign_out_y", y, 32'h0200_0000);
    check("ign_out_valid", {31'b0, out_valid}, 32'd1);
    handshake();
    @(negedge clk);
    check("ign_out_no_restart", {31'b0, busy}, 32'd0);

    // in_valid in IDLE is ignored
    in_valid = 1'b1; x = 32'h7F00_0000; w = 32'h7F00_0000;
    repeat (3) @(negedge clk);
    check("idle_in_ready", {31'b0, in_ready}, 32'd0);
    check("idle_no_busy", {31'b0, busy}, 32'd0);
    in_valid = 1'b0;
    run_op(32'h0, 32'h0100_0000, 32'h0080_0000, 0);
    check("idle_valid_y", y, 32'h0200_0000);
    handshake();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
